// File: rtl/symbol_upsampler.sv
// rtl/symbol_upsampler.sv - PAM4 symbol buffer and OSR-times upsampler (zero-stuff, or hold when SYMBOL_UPSAMPLER_HOLD_EN)
module symbol_upsampler #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_A    = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            sym_data,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic                  sample_en,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  underrun,
    input  logic                  underrun_clr
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(OSR);
    localparam logic signed [DATA_WIDTH-1:0] LVL1 = DATA_WIDTH'(LEVEL_A);
    localparam logic signed [DATA_WIDTH-1:0] LVL3 = DATA_WIDTH'(3 * LEVEL_A);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [1:0]             mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic [DATA_WIDTH-1:0]  lvl_q, lvl_d;
    logic                   valid_q;
    logic                   und_q, und_d;
    logic                   rdy_q;
    logic                   push, pop, und_set;

    function automatic logic [DATA_WIDTH-1:0] map_sym(input logic [1:0] s);
        case (s)
            2'b00:   map_sym = -LVL3;
            2'b01:   map_sym = -LVL1;
            2'b11:   map_sym = LVL1;
            default: map_sym = LVL3;
        endcase
    endfunction

    // rdy_q keeps sym_ready low throughout reset and rises on the first edge after release
    assign sym_ready    = rdy_q && (count_q < CW'(FIFO_DEPTH));
    assign push         = sym_valid && sym_ready;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign underrun     = und_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        out_d   = out_q;
        lvl_d   = lvl_q;
        pop     = 1'b0;
        und_set = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        lvl_d   = map_sym(mem_q[rd_ptr_q]);
                        out_d   = map_sym(mem_q[rd_ptr_q]);
                        phase_d = PW'(1);
                        state_d = ACTIVE;
                    end else begin
                        out_d = '0;
                    end
                end
                default: begin
                    if (phase_q != '0) begin
`ifdef SYMBOL_UPSAMPLER_HOLD_EN
                        out_d = lvl_q;
`else
                        out_d = '0;
`endif
                        phase_d = (phase_q == PW'(OSR - 1)) ? '0 : phase_q + PW'(1);
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        lvl_d   = map_sym(mem_q[rd_ptr_q]);
                        out_d   = map_sym(mem_q[rd_ptr_q]);
                        phase_d = PW'(1);
                    end else begin
                        out_d   = '0;
                        und_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
        // a new underrun takes priority over a coincident clear
        und_d = und_set ? 1'b1 : (underrun_clr ? 1'b0 : und_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            lvl_q    <= '0;
            valid_q  <= 1'b0;
            und_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            lvl_q   <= lvl_d;
            valid_q <= sample_en;
            und_q   <= und_d;
            rdy_q   <= 1'b1;
            if (push)
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= sym_data;
    end
endmodule
